// File: rtl/nand3_cell_bist_seq.sv
// rtl/nand3_cell_bist_seq.sv - BIST sequencer for one 3-input NAND cell
module nand3_cell_bist_seq #(
    parameter int SETTLE_CYC = 2,
    parameter int PASSES     = 1,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ZN_IN,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [2:0]       FAIL_VEC
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       SCNT_RELOAD = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]       PCNT_LAST   = 4'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic [7:0]         scnt_q, scnt_d;
    logic [3:0]         pcnt_q, pcnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_vld_q, fail_vld_d;
    logic [2:0]         fail_vec_q, fail_vec_d;
    logic               mismatch;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        scnt_d     = scnt_q;
        pcnt_d     = pcnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        mismatch   = (ZN_IN != ~&vec_q);

        // Abort outranks everything; the result registers are left for the host to inspect.
        if (ABORT) begin
            state_d = ST_IDLE;
            vec_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d    = ST_SETTLE;
                        vec_d      = 3'd0;
                        scnt_d     = SCNT_RELOAD;
                        pcnt_d     = 4'd0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        err_d      = '0;
                        fail_vld_d = 1'b0;
                        fail_vec_d = 3'd0;
                    end
                end
                ST_SETTLE: begin
                    if (scnt_q == 8'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        scnt_d = scnt_q - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_ONE;
                        end
                        if (!fail_vld_q) begin
                            fail_vld_d = 1'b1;
                            fail_vec_d = vec_q;
                        end
                    end
                    scnt_d = SCNT_RELOAD;
                    if (vec_q != 3'd7) begin
                        vec_d   = vec_q + 3'd1;
                        state_d = ST_SETTLE;
                    end else if (pcnt_q != PCNT_LAST) begin
                        vec_d   = 3'd0;
                        pcnt_d  = pcnt_q + 4'd1;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q    <= ST_IDLE;
            vec_q      <= 3'd0;
            scnt_q     <= 8'd0;
            pcnt_q     <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            scnt_q     <= scnt_d;
            pcnt_q     <= pcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // vec is forced to 0 on every entry to IDLE, so it can drive the CUT directly.
    assign A1       = vec_q[0];
    assign A2       = vec_q[1];
    assign A3       = vec_q[2];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_nand3_cell_bist_seq.sv
// tb/tb_nand3_cell_bist_seq.sv - self-checking bench for nand3_cell_bist_seq
module tb_nand3_cell_bist_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rn;
    logic            abort_i;
    logic [2:0]      start_v;
    logic            zn_rand;
    int              mode [3];
    logic [2:0][2:0] a_w;
    logic [2:0][2:0] fvec_w;
    logic [2:0]      busy_w, done_w, pass_w, fvld_w, zn_w;
    logic [7:0]      err0, err1;
    logic [1:0]      err2;

    int S_of [3] = '{2, 1, 3};
    int P_of [3] = '{1, 2, 1};
    int W_of [3] = '{8, 8, 2};

    int n_checks = 0;
    int n_errs   = 0;

    int         m_err;
    logic       m_fvld;
    logic [2:0] m_fvec;
    logic       m_aborted;

    // CUT fault models: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 wrong at vec 101, 4 random
    function automatic logic cut_zn(input int md, input logic [2:0] a, input logic r);
        case (md)
            0:       return ~&a;
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (a == 3'd5) ? &a : ~&a;
            default: return r;
        endcase
    endfunction

    assign zn_w[0] = cut_zn(mode[0], a_w[0], zn_rand);
    assign zn_w[1] = cut_zn(mode[1], a_w[1], zn_rand);
    assign zn_w[2] = cut_zn(mode[2], a_w[2], zn_rand);

    nand3_cell_bist_seq #(.SETTLE_CYC(2), .PASSES(1), .ERR_W(8)) dut0 (
        .CLK(clk), .RN(rn), .START(start_v[0]), .ABORT(abort_i), .ZN_IN(zn_w[0]),
        .A1(a_w[0][0]), .A2(a_w[0][1]), .A3(a_w[0][2]),
        .BUSY(busy_w[0]), .DONE(done_w[0]), .PASS(pass_w[0]), .ERR_CNT(err0),
        .FAIL_VLD(fvld_w[0]), .FAIL_VEC(fvec_w[0])
    );

    nand3_cell_bist_seq #(.SETTLE_CYC(1), .PASSES(2), .ERR_W(8)) dut1 (
        .CLK(clk), .RN(rn), .START(start_v[1]), .ABORT(abort_i), .ZN_IN(zn_w[1]),
        .A1(a_w[1][0]), .A2(a_w[1][1]), .A3(a_w[1][2]),
        .BUSY(busy_w[1]), .DONE(done_w[1]), .PASS(pass_w[1]), .ERR_CNT(err1),
        .FAIL_VLD(fvld_w[1]), .FAIL_VEC(fvec_w[1])
    );

    nand3_cell_bist_seq #(.SETTLE_CYC(3), .PASSES(1), .ERR_W(2)) dut2 (
        .CLK(clk), .RN(rn), .START(start_v[2]), .ABORT(abort_i), .ZN_IN(zn_w[2]),
        .A1(a_w[2][0]), .A2(a_w[2][1]), .A3(a_w[2][2]),
        .BUSY(busy_w[2]), .DONE(done_w[2]), .PASS(pass_w[2]), .ERR_CNT(err2),
        .FAIL_VLD(fvld_w[2]), .FAIL_VEC(fvec_w[2])
    );

    function automatic logic [7:0] err_of(input int idx);
        case (idx)
            0:       return err0;
            1:       return err1;
            default: return {6'd0, err2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector at cycle c of a run is c/(S+1) mod 8; the last cycle of each slot is the sample.
    task automatic run(input int idx, input int abort_at);
        int       s;
        int       n;
        int       maxe;
        int       seq_bad;
        logic [2:0] v;
        s         = S_of[idx];
        n         = 8 * P_of[idx] * (s + 1);
        maxe      = (1 << W_of[idx]) - 1;
        seq_bad   = 0;
        m_err     = 0;
        m_fvld    = 1'b0;
        m_fvec    = 3'd0;
        m_aborted = 1'b0;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i   = 1'b0;
                m_aborted = 1'b1;
                check("seq_before_abort", seq_bad, 0);
                return;
            end
            zn_rand = 1'($urandom_range(0, 1));
            #1;
            v = 3'((c / (s + 1)) % 8);
            if (a_w[idx] !== v || busy_w[idx] !== 1'b1 || done_w[idx] !== 1'b0) seq_bad++;
            if ((c % (s + 1)) == s && zn_w[idx] !== ~&v) begin
                if (m_err < maxe) m_err++;
                if (!m_fvld) begin
                    m_fvld = 1'b1;
                    m_fvec = v;
                end
            end
            tick();
        end
        check("seq", seq_bad, 0);
    endtask

    task automatic check_end(input int idx, input int e_err, input logic e_fvld,
                             input logic [2:0] e_fvec, input logic e_pass, input logic e_done);
        check("done", done_w[idx], e_done);
        check("busy", busy_w[idx], 1'b0);
        check("a_out", a_w[idx], e_done ? 3'd7 : 3'd0);
        check("err_cnt", err_of(idx), e_err);
        check("fail_vld", fvld_w[idx], e_fvld);
        check("fail_vec", fvec_w[idx], e_fvec);
        check("pass", pass_w[idx], e_pass);
    endtask

    typedef struct {
        int         idx;
        int         md;
        int         err;
        logic       fvld;
        logic [2:0] fvec;
        logic       pass;
    } row_t;

    row_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 0, 1'b0, 3'd0, 1'b1};
        tbl[1] = '{0, 1, 1, 1'b1, 3'd7, 1'b0};
        tbl[2] = '{0, 2, 7, 1'b1, 3'd0, 1'b0};
        tbl[3] = '{0, 3, 1, 1'b1, 3'd5, 1'b0};
        tbl[4] = '{1, 1, 2, 1'b1, 3'd7, 1'b0};
        tbl[5] = '{1, 0, 0, 1'b0, 3'd0, 1'b1};
        tbl[6] = '{2, 2, 3, 1'b1, 3'd0, 1'b0};
        tbl[7] = '{2, 3, 1, 1'b1, 3'd5, 1'b0};

        rn      = 1'b0;
        abort_i = 1'b0;
        start_v = 3'd0;
        zn_rand = 1'b0;
        for (int i = 0; i < 3; i++) mode[i] = 0;
        tick();
        tick();
        check_end(0, 0, 1'b0, 3'd0, 1'b0, 1'b0);
        rn = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) begin
            mode[tbl[r].idx] = tbl[r].md;
            run(tbl[r].idx, -1);
            check_end(tbl[r].idx, tbl[r].err, tbl[r].fvld, tbl[r].fvec, tbl[r].pass, 1'b1);
            tick();
        end

        // Abort on the 10th cycle of a run with a random CUT
        mode[0] = 4;
        run(0, 9);
        check_end(0, m_err, m_fvld, m_fvec, 1'b0, 1'b0);
        start_v[0] = 1'b1;
        abort_i    = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_i    = 1'b0;
        tick();
        check("start_with_abort_busy", busy_w[0], 1'b0);
        check("start_with_abort_err", err_of(0), m_err);

        // Abort from DONE returns the CUT inputs to 000
        mode[0] = 1;
        run(0, -1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_end(0, 1, 1'b1, 3'd7, 1'b0, 1'b0);

        // Reset landing on the CHECK of vector 001 after a mismatch at 000
        mode[0] = 2;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rn = 1'b0;
        tick();
        rn = 1'b1;
        check_end(0, 0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        mode[0] = 1;
        run(0, -1);
        check_end(0, 1, 1'b1, 3'd7, 1'b0, 1'b1);
        mode[0] = 0;
        run(0, -1);
        check_end(0, 0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Random CUT responses, random target, occasional abort
        for (int r = 0; r < 8; r++) begin
            int idx;
            int n;
            int ab;
            idx = int'($urandom_range(0, 2));
            n   = 8 * P_of[idx] * (S_of[idx] + 1);
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            mode[idx] = 4;
            run(idx, ab);
            check_end(idx, m_err, m_fvld, m_fvec, !m_aborted && (m_err == 0), !m_aborted);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
